// File: rtl/renode_pkg.sv
// Shared types for the renode input-event reporter and its callers.
// Latency: none (types, constants and a helper function only).
// Backpressure: not applicable.
package renode_pkg;

  // Per-channel edge qualification mode. LEVEL_HIGH reports a rise only when
  // armed, disarms on report and re-arms on the next fall.
  typedef enum logic [1:0] {
    MODE_ANY        = 2'd0,
    MODE_RISE       = 2'd1,
    MODE_FALL       = 2'd2,
    MODE_LEVEL_HIGH = 2'd3
  } edge_mode_e;

  // Widest channel index the block supports (256 channels).
  localparam int MaxAddrWidth = 8;

  // Caller-facing event record at the widest address width. Callers zero-extend
  // ev_addr into it when forming async-receiver messages.
  typedef struct packed {
    logic [MaxAddrWidth-1:0] addr;
    logic                    level;
  } input_event_t;

  // Address width for a channel count, never below one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/renode_event_fifo.sv
// Event FIFO whose head sits in a registered output stage; the output register
//   counts toward occupancy, so Depth entries total. Latency: push at edge t is
//   visible at o_vld after edge t+1. Backpressure: push is dropped only when full
//   and not popping. Ports: i_push/i_push_dat write side, o_full, o_vld/i_rdy/o_dat
//   read side, o_count post-edge occupancy.
module renode_event_fifo #(
  parameter  int Width = 6,
  parameter  int Depth = 8,
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntW  = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_push_dat,
  output logic             o_full,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [Width-1:0] o_dat,
  output logic [CntW-1:0]  o_count
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_mem_cnt;
  logic             r_out_vld;
  logic [Width-1:0] r_out_dat;

  logic w_pop;
  logic w_load;
  logic w_wr;

  assign w_pop   = r_out_vld & i_rdy;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign w_load  = (r_mem_cnt != '0) & (~r_out_vld | w_pop);
  assign o_count = r_mem_cnt + CntW'(r_out_vld);
  assign o_full  = (o_count == CntW'(Depth));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_wr    = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_load) begin
        r_out_dat <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + PtrW'(1);
      end
      r_out_vld <= w_load | (r_out_vld & ~w_pop);
      r_mem_cnt <= r_mem_cnt + CntW'(w_wr) - CntW'(w_load);
    end
  end

  assign o_vld = r_out_vld;
  assign o_dat = r_out_dat;

endmodule

// File: rtl/renode_input_events.sv
// Synchronise/debounce async input lines, qualify edges per channel, coalesce into
//   pending bits and round-robin them into an event FIFO. Latency: capture edge k
//   -> ev_valid after edge k+SyncStages+2 (no debounce, idle). Backpressure: a full
//   FIFO holds pending bits; later events overwrite the pending level (coalesce).
// Ports: clk/rst_n, inputs, chan_enable, chan_mode (edge_mode_e per channel),
//   ev_valid/ev_ready/ev_addr/ev_level stream, fifo_count, coalesced_count.
module renode_input_events
  import renode_pkg::*;
#(
  parameter  int InputsCount    = 32,
  parameter  int SyncStages     = 2,
  parameter  int DebounceCycles = 0,
  parameter  int FifoDepth      = 8,
  localparam int AddrWidth      = addr_width(InputsCount),
  localparam int CountWidth     = $clog2(FifoDepth) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [InputsCount-1:0]      inputs,
  input  logic [InputsCount-1:0]      chan_enable,
  input  logic [InputsCount-1:0][1:0] chan_mode,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [AddrWidth-1:0]        ev_addr,
  output logic                        ev_level,
  output logic [CountWidth-1:0]       fifo_count,
  output logic [15:0]                 coalesced_count
);

  localparam int WarmCycles = SyncStages + DebounceCycles + 1;
  localparam int WarmW      = $clog2(WarmCycles + 1);
  localparam int IdxW       = AddrWidth + 1;
  localparam int PopW       = $clog2(InputsCount + 1);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 level;
  } evt_t;

  logic [InputsCount-1:0] r_sync [SyncStages];
  logic [InputsCount-1:0] w_sync, w_stable, r_stable_prev;
  logic [InputsCount-1:0] w_rise, w_fall, w_qual, w_is_lh, w_clr, w_coal;
  logic [InputsCount-1:0] r_pending, r_pend_level, r_disarmed;
  logic [WarmW-1:0]       r_warm;
  logic                   w_warm_done;
  logic [AddrWidth-1:0]   r_rr_ptr, w_gnt_idx;
  logic [IdxW-1:0]        w_idx;
  logic                   w_gnt_vld, w_push, w_fifo_full, w_ev_vld;
  logic [PopW-1:0]        w_coal_n;
  logic [16:0]            w_coal_sum;
  logic [15:0]            r_coal_cnt;
  evt_t                   w_push_evt, w_head_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SyncStages; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= inputs;
      for (int s = 1; s < SyncStages; s++) r_sync[s] <= r_sync[s-1];
    end
  end
  assign w_sync = r_sync[SyncStages-1];

  if (DebounceCycles == 0) begin : g_no_db
    assign w_stable = w_sync;
  end else begin : g_db
    localparam int DbW = $clog2(DebounceCycles + 1);
    logic [DbW-1:0]         r_db_cnt [InputsCount];
    logic [InputsCount-1:0] r_stable;
    // Counts consecutive cycles the synced line disagrees with the accepted
    // level; the new level is taken on the DebounceCycles-th such cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < InputsCount; i++) r_db_cnt[i] <= '0;
        r_stable <= '0;
      end else begin
        for (int i = 0; i < InputsCount; i++) begin
          if (w_sync[i] == r_stable[i]) begin
            r_db_cnt[i] <= '0;
          end else if (r_db_cnt[i] == DbW'(DebounceCycles - 1)) begin
            r_stable[i] <= w_sync[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DbW'(1);
          end
        end
      end
    end
    assign w_stable = r_stable;
  end

  // Events stay masked until the sync/debounce pipeline has flushed the reset
  // value, so lines already high at release are absorbed silently.
  assign w_warm_done = (r_warm == WarmW'(WarmCycles));
  assign w_rise      = w_stable & ~r_stable_prev;
  assign w_fall      = ~w_stable & r_stable_prev;

  always_comb begin
    w_qual  = '0;
    w_is_lh = '0;
    for (int i = 0; i < InputsCount; i++) begin
      case (edge_mode_e'(chan_mode[i]))
        MODE_ANY:        w_qual[i] = w_rise[i] | w_fall[i];
        MODE_RISE:       w_qual[i] = w_rise[i];
        MODE_FALL:       w_qual[i] = w_fall[i];
        MODE_LEVEL_HIGH: begin
          w_qual[i]  = w_rise[i] & ~r_disarmed[i];
          w_is_lh[i] = 1'b1;
        end
        default:         w_qual[i] = 1'b0;
      endcase
    end
    w_qual = w_qual & chan_enable & {InputsCount{w_warm_done}};
  end

  // Round-robin: scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int k = InputsCount - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + IdxW'(k);
      if (w_idx >= IdxW'(InputsCount)) w_idx = w_idx - IdxW'(InputsCount);
      if (r_pending[w_idx[AddrWidth-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx[AddrWidth-1:0];
      end
    end
  end

  assign w_push = w_gnt_vld & (~w_fifo_full | (w_ev_vld & ev_ready));

  always_comb begin
    w_clr = '0;
    if (w_push) w_clr[w_gnt_idx] = 1'b1;
  end

  // A new event on a channel being granted this cycle re-pends it; not a merge.
  assign w_coal = w_qual & r_pending & ~w_clr;

  always_comb begin
    w_coal_n = '0;
    for (int i = 0; i < InputsCount; i++) w_coal_n = w_coal_n + PopW'(w_coal[i]);
  end
  assign w_coal_sum = {1'b0, r_coal_cnt} + 17'(w_coal_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm        <= '0;
      r_stable_prev <= '0;
      r_pending     <= '0;
      r_pend_level  <= '0;
      r_disarmed    <= '0;
      r_rr_ptr      <= '0;
      r_coal_cnt    <= '0;
    end else begin
      if (!w_warm_done) r_warm <= r_warm + WarmW'(1);
      r_stable_prev <= w_stable;
      r_pending     <= ((r_pending & ~w_clr) | w_qual) & chan_enable;
      r_pend_level  <= (r_pend_level & ~w_qual) | (w_stable & w_qual);
      r_disarmed    <= (r_disarmed | (w_qual & w_is_lh)) & ~w_fall;
      if (w_push) begin
        r_rr_ptr <= (w_gnt_idx == AddrWidth'(InputsCount - 1)) ? '0
                                                                : w_gnt_idx + AddrWidth'(1);
      end
      r_coal_cnt <= w_coal_sum[16] ? 16'hFFFF : w_coal_sum[15:0];
    end
  end

  assign w_push_evt.addr  = w_gnt_idx;
  assign w_push_evt.level = r_pend_level[w_gnt_idx];

  renode_event_fifo #(
    .Width($bits(evt_t)),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_push_dat(w_push_evt),
    .o_full    (w_fifo_full),
    .o_vld     (w_ev_vld),
    .i_rdy     (ev_ready),
    .o_dat     (w_head_evt),
    .o_count   (fifo_count)
  );

  assign ev_valid        = w_ev_vld;
  assign ev_addr         = w_head_evt.addr;
  assign ev_level        = w_head_evt.level;
  assign coalesced_count = r_coal_cnt;

endmodule

// File: tb/tb_renode_input_events.sv
// Directed bench for renode_input_events: a no-debounce instance for latency,
// mode qualification, FIFO-full coalescing and reset, plus a debounced instance.
module tb_renode_input_events;
  import renode_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [N-1:0]       inputs, chan_enable, db_inputs;
  logic [N-1:0][1:0]  chan_mode, db_mode;
  logic               ev_ready, ev_valid, ev_level;
  logic [4:0]         ev_addr;
  logic [3:0]         fifo_count;
  logic [15:0]        coalesced_count;
  logic               db_ready, db_valid, db_level;
  logic [4:0]         db_addr;
  logic [3:0]         db_count;
  logic [15:0]        db_coal;

  renode_input_events #(
    .InputsCount(N), .SyncStages(2), .DebounceCycles(0), .FifoDepth(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .inputs(inputs), .chan_enable(chan_enable),
    .chan_mode(chan_mode), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_addr(ev_addr), .ev_level(ev_level), .fifo_count(fifo_count),
    .coalesced_count(coalesced_count)
  );

  renode_input_events #(
    .InputsCount(N), .SyncStages(2), .DebounceCycles(4), .FifoDepth(8)
  ) u_db (
    .clk(clk), .rst_n(rst_n), .inputs(db_inputs), .chan_enable(chan_enable),
    .chan_mode(db_mode), .ev_valid(db_valid), .ev_ready(db_ready),
    .ev_addr(db_addr), .ev_level(db_level), .fifo_count(db_count),
    .coalesced_count(db_coal)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Popped events as {addr, level}; a pop happens at the next posedge when
  // valid && ready hold here, since inputs only change just after posedge.
  logic [5:0] q[$];
  logic [5:0] qd[$];
  always @(negedge clk) begin
    if (ev_valid && ev_ready) q.push_back({ev_addr, ev_level});
    if (db_valid && db_ready) qd.push_back({db_addr, db_level});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [4:0] ch;
    logic [1:0] mode;
    logic       en;
    logic       lvl;
    int         exp_n;
    logic       exp_lvl;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Mode-qualification table; channel 0 starts high, the rest low.
    vecs[0]  = '{5'd3, 2'd1, 1'b1, 1'b1, 1, 1'b1};  // RISE, rising
    vecs[1]  = '{5'd3, 2'd1, 1'b1, 1'b0, 0, 1'b0};  // RISE, falling
    vecs[2]  = '{5'd3, 2'd2, 1'b1, 1'b1, 0, 1'b0};  // FALL, rising
    vecs[3]  = '{5'd3, 2'd2, 1'b1, 1'b0, 1, 1'b0};  // FALL, falling
    vecs[4]  = '{5'd3, 2'd3, 1'b1, 1'b1, 1, 1'b1};  // LEVEL_HIGH first pulse
    vecs[5]  = '{5'd3, 2'd3, 1'b1, 1'b0, 0, 1'b0};  // fall re-arms, silent
    vecs[6]  = '{5'd3, 2'd3, 1'b1, 1'b1, 1, 1'b1};  // LEVEL_HIGH second pulse
    vecs[7]  = '{5'd3, 2'd3, 1'b1, 1'b0, 0, 1'b0};
    vecs[8]  = '{5'd0, 2'd0, 1'b1, 1'b0, 1, 1'b0};  // ANY, falling
    vecs[9]  = '{5'd5, 2'd0, 1'b0, 1'b1, 0, 1'b0};  // disabled
    vecs[10] = '{5'd5, 2'd0, 1'b0, 1'b0, 0, 1'b0};
    vecs[11] = '{5'd5, 2'd0, 1'b1, 1'b1, 1, 1'b1};  // re-enabled

    rst_n       = 1'b0;
    inputs      = 32'h0000_0005;
    chan_enable = '1;
    chan_mode   = '0;
    ev_ready    = 1'b1;
    db_inputs   = '0;
    db_mode     = '0;
    db_mode[1]  = 2'd1;
    db_ready    = 1'b1;
    tick(3);
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_ev_addr", 32'(ev_addr), 32'd0);
    check("rst_ev_level", 32'(ev_level), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_coalesced", 32'(coalesced_count), 32'd0);

    rst_n = 1'b1;
    tick(12);
    check("warmup_no_events", 32'(q.size()), 32'd0);

    // Latency: bit 2 falls, captured at the next edge k; valid after k+4.
    q.delete();
    inputs[2] = 1'b0;
    tick(4);
    check("lat_not_yet_valid", 32'(ev_valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(ev_valid), 32'd1);
    check("lat_addr", 32'(ev_addr), 32'd2);
    check("lat_level", 32'(ev_level), 32'd0);
    tick(6);
    check("lat_single_event", 32'(q.size()), 32'd1);

    for (int v = 0; v < 12; v++) begin
      q.delete();
      chan_mode[vecs[v].ch]   = vecs[v].mode;
      chan_enable[vecs[v].ch] = vecs[v].en;
      inputs[vecs[v].ch]      = vecs[v].lvl;
      tick(8);
      check($sformatf("vec%0d_count", v), 32'(q.size()), 32'(vecs[v].exp_n));
      if (vecs[v].exp_n == 1 && q.size() > 0)
        check($sformatf("vec%0d_event", v), 32'(q[0]), 32'({vecs[v].ch, vecs[v].exp_lvl}));
    end

    // FIFO full: restart so the round-robin pointer is back at 0.
    rst_n       = 1'b0;
    inputs      = '0;
    chan_mode   = '0;
    chan_enable = '1;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    q.delete();
    ev_ready     = 1'b0;
    inputs[9:0]  = 10'h3FF;
    tick(20);
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_head_valid", 32'(ev_valid), 32'd1);
    check("full_head_event", 32'({ev_addr, ev_level}), 32'({5'd0, 1'b1}));

    // Channel 8 is pending behind a full FIFO: three more edges merge into it.
    for (int t = 0; t < 3; t++) begin
      inputs[8] = ~inputs[8];
      tick(5);
    end
    check("coalesced_3", 32'(coalesced_count), 32'd3);
    check("full_count_held", 32'(fifo_count), 32'd8);

    // Briefly disabling channel 9 discards its pending event.
    chan_enable[9] = 1'b0;
    tick(2);
    chan_enable[9] = 1'b1;
    tick(2);

    ev_ready = 1'b1;
    tick(20);
    check("drain_count", 32'(q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < q.size())
        check($sformatf("drain%0d", i), 32'(q[i]), 32'({i[4:0], (i == 8) ? 1'b0 : 1'b1}));
    end
    check("fifo_empty_after_drain", 32'(fifo_count), 32'd0);

    // Reset with events queued.
    q.delete();
    ev_ready    = 1'b0;
    inputs[3:0] = 4'h0;
    tick(12);
    check("queued_before_reset", 32'(fifo_count), 32'd4);
    rst_n = 1'b0;
    #1;
    check("midrst_ev_valid", 32'(ev_valid), 32'd0);
    check("midrst_fifo_count", 32'(fifo_count), 32'd0);
    check("midrst_coalesced", 32'(coalesced_count), 32'd0);
    tick(2);
    rst_n    = 1'b1;
    ev_ready = 1'b1;
    tick(15);
    check("post_reset_no_events", 32'(q.size()), 32'd0);

    // Debounce 4: a 3-cycle glitch is rejected, a 4-cycle pulse is accepted.
    qd.delete();
    db_inputs[1] = 1'b1;
    tick(3);
    db_inputs[1] = 1'b0;
    tick(20);
    check("db_glitch_rejected", 32'(qd.size()), 32'd0);
    db_inputs[1] = 1'b1;
    tick(4);
    db_inputs[1] = 1'b0;
    tick(25);
    check("db_hold_count", 32'(qd.size()), 32'd1);
    if (qd.size() > 0) check("db_hold_event", 32'(qd[0]), 32'({5'd1, 1'b1}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
